// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the seven-segment scan controller.
//   SEG_OFF      - all cathodes released (active-low segments dark)
//   DIG_OFF      - all anodes released (active-low digits dark)
//   NUM_DIGITS   - number of time-multiplexed digits on the shared bus
//   scan_state_e - phase within a digit slot (BLANK gap, then ON)
//   anode_sel    - one-cold anode pattern selecting a single digit
package ssd_pkg;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] DIG_OFF    = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  // Active-low anode vector with only digit idx pulled low.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// ssd_slot_timer: per-slot cycle counter for the digit scan.
//   clk, rst    - board clock, synchronous active-high reset
//   clr         - parks the counter at 0 (used while scanning is disabled)
//   adv         - advance the counter this cycle
//   in_blank    - counter is inside the leading anti-ghosting gap
//   slot_start  - counter is at the first cycle of a slot
//   slot_end    - counter is at the last cycle of a slot and advancing
module ssd_slot_timer #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int ADDR_W       = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic in_blank,
  output logic slot_start,
  output logic slot_end
);

  localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'(SLOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BLANK_LIM = ADDR_W'(BLANK_CYCLES);
  localparam logic [ADDR_W-1:0] CNT_ZERO  = '0;
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] slot_cnt_r;

  // Slot counter: counts 0..SLOT_CYCLES-1 and wraps; held at 0 while cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_r <= CNT_ZERO;
    end else if (clr) begin
      slot_cnt_r <= CNT_ZERO;
    end else if (adv) begin
      if (slot_cnt_r == SLOT_LAST) begin
        slot_cnt_r <= CNT_ZERO;
      end else begin
        slot_cnt_r <= slot_cnt_r + CNT_ONE;
      end
    end else begin
      slot_cnt_r <= slot_cnt_r;
    end
  end

  // Slot phase decode from the current count.
  always_comb begin
    in_blank   = 1'b0;
    slot_start = 1'b0;
    slot_end   = 1'b0;
    if (slot_cnt_r < BLANK_LIM) begin
      in_blank = 1'b1;
    end else begin
      in_blank = 1'b0;
    end
    if (slot_cnt_r == CNT_ZERO) begin
      slot_start = 1'b1;
    end else begin
      slot_start = 1'b0;
    end
    if (adv && (slot_cnt_r == SLOT_LAST)) begin
      slot_end = 1'b1;
    end else begin
      slot_end = 1'b0;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: round-robin time-multiplexer for a shared 4-digit seven-segment bus.
// Each digit owns a fixed slot: a blank gap with all anodes off, then an ON phase where
// the digit is PWM-driven. Segment codes are latched once per frame to avoid tearing.
//   clk, rst      - board clock, synchronous active-high reset
//   en            - 1 scans, 0 darkens the display and parks the scheduler
//   bright        - ON-phase duty; digit driven while pwm count <= bright
//   blank_mask    - bit i keeps digit i dark (its slot is still consumed)
//   disp0..disp3  - active-low segment codes {dp,g..a} for each digit
//   seven         - registered segment cathodes, active-low
//   segment       - registered digit anodes, active-low, at most one low
//   frame_start   - high during the cycle the shadow registers load
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int ADDR_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] bright,
  input  logic [3:0] blank_mask,
  input  logic [7:0] disp0,
  input  logic [7:0] disp1,
  input  logic [7:0] disp2,
  input  logic [7:0] disp3,
  output logic [7:0] seven,
  output logic [3:0] segment,
  output logic       frame_start
);

  if (BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
    $error("ssd_scan_ctrl: BLANK_CYCLES must be smaller than SLOT_CYCLES");
  end
  if ((SLOT_CYCLES - 1) >= (2 ** ADDR_W)) begin : g_bad_addr
    $error("ssd_scan_ctrl: ADDR_W too narrow for SLOT_CYCLES");
  end

  scan_state_e state_s;
  logic        in_blank_s;
  logic        slot_start_s;
  logic        slot_end_s;
  logic        frame_start_s;
  logic        drive_s;
  logic [1:0]  idx_r;
  logic [2:0]  pwm_cnt_r;
  logic [7:0]  shadow_r [NUM_DIGITS];
  logic [7:0]  disp_s   [NUM_DIGITS];
  logic [7:0]  seven_r;
  logic [3:0]  segment_r;
  logic [7:0]  seven_nxt_s;
  logic [3:0]  segment_nxt_s;

  ssd_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .ADDR_W       (ADDR_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (~en),
    .adv        (en),
    .in_blank   (in_blank_s),
    .slot_start (slot_start_s),
    .slot_end   (slot_end_s)
  );

  assign disp_s[0] = disp0;
  assign disp_s[1] = disp1;
  assign disp_s[2] = disp2;
  assign disp_s[3] = disp3;

  // Scan phase follows the slot counter directly, so it can never drift from it.
  always_comb begin
    state_s = BLANK;
    if (in_blank_s) begin
      state_s = BLANK;
    end else begin
      state_s = ON;
    end
  end

  // Frame start: first BLANK cycle of digit 0 while enabled and out of reset.
  always_comb begin
    frame_start_s = 1'b0;
    if (!rst && en && slot_start_s && (idx_r == 2'd0) && (state_s == BLANK)) begin
      frame_start_s = 1'b1;
    end else begin
      frame_start_s = 1'b0;
    end
  end

  assign frame_start = frame_start_s;

  // Next pin values: dark unless enabled, in the ON phase, inside the PWM window and unmasked.
  always_comb begin
    seven_nxt_s   = SEG_OFF;
    segment_nxt_s = DIG_OFF;
    drive_s       = (pwm_cnt_r <= bright) && !blank_mask[idx_r];
    if (en) begin
      case (state_s)
        BLANK: begin
          seven_nxt_s   = SEG_OFF;
          segment_nxt_s = DIG_OFF;
        end
        ON: begin
          if (drive_s) begin
            seven_nxt_s   = shadow_r[idx_r];
            segment_nxt_s = anode_sel(idx_r);
          end else begin
            seven_nxt_s   = SEG_OFF;
            segment_nxt_s = DIG_OFF;
          end
        end
        default: begin
          seven_nxt_s   = SEG_OFF;
          segment_nxt_s = DIG_OFF;
        end
      endcase
    end else begin
      seven_nxt_s   = SEG_OFF;
      segment_nxt_s = DIG_OFF;
    end
  end

  // Pin registers: one cycle behind the internal scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seven_r   <= SEG_OFF;
      segment_r <= DIG_OFF;
    end else begin
      seven_r   <= seven_nxt_s;
      segment_r <= segment_nxt_s;
    end
  end

  assign seven   = seven_r;
  assign segment = segment_r;

  // PWM counter: parked at 0 through the blank gap so every ON phase starts at duty step 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_r <= 3'd0;
    end else if (!en || (state_s == BLANK)) begin
      pwm_cnt_r <= 3'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 3'd1;
    end
  end

  // Digit index: advances on each slot end, wrapping 3 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= 2'd0;
    end else if (!en) begin
      idx_r <= 2'd0;
    end else if (slot_end_s) begin
      idx_r <= idx_r + 2'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Shadow registers: all digit codes sampled together at frame start only.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (rst) begin
        shadow_r[i] <= SEG_OFF;
      end else if (frame_start_s) begin
        shadow_r[i] <= disp_s[i];
      end else begin
        shadow_r[i] <= shadow_r[i];
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed self-checking bench for ssd_scan_ctrl with
// SLOT_CYCLES=8, BLANK_CYCLES=2 (frame = 32 cycles).
module tb_ssd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] bright;
  logic [3:0] blank_mask;
  logic [7:0] disp0, disp1, disp2, disp3;
  logic [7:0] seven;
  logic [3:0] segment;
  logic       frame_start;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;          // cycles since the last frame-0 start of the scheduler
  logic [7:0] exp_sh [4];  // codes the bench expects to be latched for this frame

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2),
    .ADDR_W       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bright      (bright),
    .blank_mask  (blank_mask),
    .disp0       (disp0),
    .disp1       (disp1),
    .disp2       (disp2),
    .disp3       (disp3),
    .seven       (seven),
    .segment     (segment),
    .frame_start (frame_start)
  );

  function automatic logic [3:0] anode(input int slot);
    case (slot)
      0:       return 4'hE;
      1:       return 4'hD;
      2:       return 4'hB;
      default: return 4'h7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dark_check(input string tag);
    chk({tag, " seg"}, {4'h0, segment}, 8'h0F);
    chk({tag, " seven"}, seven, 8'hFF);
    chk({tag, " fs"}, {7'h0, frame_start}, 8'h00);
  endtask

  // One enabled clock: expected pins come from the slot position of the cycle just ending.
  task automatic tick();
    int m, pos, slot, pw;
    logic [3:0] es;
    logic [7:0] ev;
    m    = cyc;
    pos  = m % 8;
    slot = (m / 8) % 4;
    es   = 4'hF;
    ev   = 8'hFF;
    if (pos >= 2) begin
      pw = pos - 2;
      if ((pw <= int'(bright)) && !blank_mask[slot]) begin
        es = anode(slot);
        ev = exp_sh[slot];
      end
    end
    if (m % 32 == 0) begin
      exp_sh[0] = disp0;
      exp_sh[1] = disp1;
      exp_sh[2] = disp2;
      exp_sh[3] = disp3;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk($sformatf("seg c%0d", cyc), {4'h0, segment}, {4'h0, es});
    chk($sformatf("seven c%0d", cyc), seven, ev);
    chk($sformatf("fs c%0d", cyc), {7'h0, frame_start}, (cyc % 32 == 0) ? 8'h01 : 8'h00);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    bright     = 3'd7;
    blank_mask = 4'b0000;
    disp0      = 8'hC0;
    disp1      = 8'hF9;
    disp2      = 8'hA4;
    disp3      = 8'hB0;

    // Reset held three cycles: dark pins, no frame pulse.
    repeat (3) begin
      @(posedge clk);
      #1;
      dark_check("reset");
    end
    rst = 1'b0;
    #1;
    chk("fs_release", {7'h0, frame_start}, 8'h01);
    cyc = 0;

    // Scan order over one full frame plus the next frame start.
    run_to(3);
    chk("slot0_first_on", seven, 8'hC0);
    run_to(32);

    // Frame latch: disp2 changed mid-frame shows only after the next frame start.
    run_to(36);
    disp2 = 8'h99;
    run_to(51);
    chk("latch_old", seven, 8'hA4);
    run_to(83);
    chk("latch_new", seven, 8'h99);
    chk("latch_new_seg", {4'h0, segment}, 8'h0B);
    run_to(96);

    // Brightness 1: driven only for pwm steps 0 and 1.
    bright = 3'd1;
    run_to(100);
    chk("bright1_step1", {4'h0, segment}, 8'h0E);
    run_to(101);
    chk("bright1_step2", {4'h0, segment}, 8'h0F);
    run_to(128);
    bright = 3'd7;

    // Mask digit 2: its slot stays dark, other slots unchanged.
    blank_mask = 4'b0100;
    run_to(147);
    chk("mask_slot2_seg", {4'h0, segment}, 8'h0F);
    chk("mask_slot2_seven", seven, 8'hFF);
    run_to(155);
    chk("mask_slot3_seg", {4'h0, segment}, 8'h07);
    run_to(160);
    blank_mask = 4'b0000;

    // Enable dropped in the ON phase of slot 1.
    run_to(172);
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      dark_check("en_off");
    end
    en = 1'b1;
    #1;
    chk("fs_en_rise", {7'h0, frame_start}, 8'h01);
    cyc = 0;
    run_to(12);

    // Reset in the ON phase of slot 3.
    run_to(27);
    rst = 1'b1;
    @(posedge clk);
    #1;
    dark_check("mid_reset");
    rst = 1'b0;
    #1;
    chk("fs_after_mid_reset", {7'h0, frame_start}, 8'h01);
    cyc = 0;
    run_to(16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
